// File: rtl/mapper_zemina_multi_pkg.sv
// Shared types and constants for the Zemina multicart mapper family.
// Page geometry and the common bank-register reload values live here.
package mapper_zemina_multi_pkg;

  typedef enum logic [1:0] {
    ZV_80   = 2'd0,
    ZV_90   = 2'd1,
    ZV_126  = 2'd2,
    ZV_NONE = 2'd3
  } zemina_variant_t;

  localparam int PAGE_8K_W  = 13;
  localparam int PAGE_16K_W = 14;

  // 0,1,2,3 is a valid start state for every variant: Z90in1 only looks at b0 (ctrl = 00h).
  localparam logic [3:0][7:0] BANK_INIT = {8'd3, 8'd2, 8'd1, 8'd0};

endpackage

// File: rtl/mapper_wr_edge.sv
// Rising-edge detector for a qualified bus write: one commit pulse per write,
// however long the strobe is held. Reset to 1 so a strobe still high after reset is ignored.
module mapper_wr_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_qual,
  output logic o_commit
);

  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_prev <= 1'b1;
    else       r_prev <= i_qual;
  end

  assign o_commit = i_qual & ~r_prev;

endmodule

// File: rtl/mapper_zemina_multi.sv
// Zemina 80-in-1 / 90-in-1 / 126-in-1 multicart mapper: bank registers plus
// combinational translation of slot addresses 4000h..BFFFh into flat ROM addresses.
module mapper_zemina_multi
  import mapper_zemina_multi_pkg::*;
#(
  parameter int          ADDR_W  = 27,
  parameter logic [7:0]  IO_PORT = 8'h77
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        variant,
  input  logic              cs,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_data,
  input  logic              cpu_mreq,
  input  logic              cpu_iorq,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] rom_base,
  input  logic [ADDR_W-1:0] rom_mask,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_rom_cs,
  output logic              out_ram_cs
);

  logic [3:0][7:0]   r_bank;
  zemina_variant_t   r_variant;
  zemina_variant_t   w_var;
  logic              w_dec;
  logic              w_qual;
  logic              w_commit;
  logic              w_mapped;
  logic [1:0]        w_widx;
  logic [7:0]        w_z90_bank;
  logic [7:0]        w_page_bank;
  logic [21:0]       w_offset;
  logic [ADDR_W-1:0] w_offset_ext;

  assign w_var = zemina_variant_t'(variant);

  always_comb begin
    w_dec  = 1'b0;
    w_widx = 2'd0;
    case (w_var)
      ZV_80: begin
        w_dec  = cs & cpu_mreq & (cpu_addr[15:2] == 14'h1000);
        w_widx = cpu_addr[1:0];
      end
      ZV_126: begin
        w_dec  = cs & cpu_mreq & (cpu_addr[15:1] == 15'h2000);
        w_widx = {1'b0, cpu_addr[0]};
      end
      // The 90-in-1 control port is decoded on the I/O bus, independent of the slot select.
      ZV_90:   w_dec = cpu_iorq & (cpu_addr[7:0] == IO_PORT);
      default: w_dec = 1'b0;
    endcase
  end

  assign w_qual = w_dec & cpu_wr;

  mapper_wr_edge u_wr_edge (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_qual   (w_qual),
    .o_commit (w_commit)
  );

  // The variant copy resets to Z80in1; the bank reset values suit every variant anyway.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_variant <= ZV_80;
      r_bank    <= BANK_INIT;
    end else if (w_var != r_variant) begin
      r_variant <= w_var;
      r_bank    <= BANK_INIT;
    end else if (w_commit) begin
      r_bank[w_widx] <= cpu_data;
    end
  end

  assign w_z90_bank = {2'b00, r_bank[0][5:0]};

  always_comb begin
    w_page_bank = 8'd0;
    w_offset    = 22'd0;
    case (w_var)
      ZV_80: begin
        // 4000h/6000h/8000h/A000h -> page 0..3 is {A15, A13} inside the window.
        w_page_bank = r_bank[{cpu_addr[15], cpu_addr[13]}];
        w_offset    = {1'b0, w_page_bank, cpu_addr[PAGE_8K_W-1:0]};
      end
      ZV_126: begin
        w_page_bank = r_bank[{1'b0, cpu_addr[15]}];
        w_offset    = {w_page_bank, cpu_addr[PAGE_16K_W-1:0]};
      end
      ZV_90: begin
        case (r_bank[0][7:6])
          2'b10:   w_page_bank = cpu_addr[15] ? (w_z90_bank | 8'h01) : (w_z90_bank & 8'hFE);
          2'b11:   w_page_bank = cpu_addr[15] ? (w_z90_bank & 8'hFE) : (w_z90_bank | 8'h01);
          default: w_page_bank = w_z90_bank;
        endcase
        w_offset = {w_page_bank, cpu_addr[PAGE_16K_W-1:0]};
      end
      default: begin
        w_page_bank = 8'd0;
        w_offset    = 22'd0;
      end
    endcase
  end

  assign w_offset_ext = {{(ADDR_W-22){1'b0}}, w_offset};
  assign w_mapped     = cs & cpu_mreq & (w_var != ZV_NONE) &
                        ((cpu_addr[15:14] == 2'b01) || (cpu_addr[15:14] == 2'b10));

  assign out_addr   = w_mapped ? (rom_base + (w_offset_ext & rom_mask)) : {ADDR_W{1'b1}};
  assign out_rom_cs = w_mapped & cpu_rd & ~cpu_wr;
  assign out_ram_cs = 1'b0;

endmodule

// File: tb/tb_mapper_zemina_multi.sv
// Directed and randomized checks of mapper_zemina_multi against a page/bank arithmetic model.
module tb_mapper_zemina_multi;

  localparam logic [26:0] ONES = 27'h7FFFFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  variant;
  logic        cs;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_mreq, cpu_iorq, cpu_wr, cpu_rd;
  logic [26:0] rom_base, rom_mask;
  logic [26:0] out_addr;
  logic        out_rom_cs, out_ram_cs;

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_var;
  logic [7:0]  m_bank [4];

  mapper_zemina_multi #(.ADDR_W(27), .IO_PORT(8'h77)) dut (
    .clk        (clk),
    .reset      (reset),
    .variant    (variant),
    .cs         (cs),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_mreq   (cpu_mreq),
    .cpu_iorq   (cpu_iorq),
    .cpu_wr     (cpu_wr),
    .cpu_rd     (cpu_rd),
    .rom_base   (rom_base),
    .rom_mask   (rom_mask),
    .out_addr   (out_addr),
    .out_rom_cs (out_rom_cs),
    .out_ram_cs (out_ram_cs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: page size, page index and bank chosen by plain arithmetic on the slot address.
  function automatic logic [26:0] exp_addr(input logic c, input logic [15:0] a);
    longint rel, psz, page, bank, off, sum;
    int     ctrl;
    if (m_var == 3 || !c || a < 16'h4000 || a > 16'hBFFF) return ONES;
    rel  = longint'(a) - 'h4000;
    psz  = (m_var == 0) ? 8192 : 16384;
    page = rel / psz;
    if (m_var == 1) begin
      ctrl = int'(m_bank[0]);
      bank = ctrl % 64;
      case (ctrl / 64)
        2: bank = (page == 0) ? bank - bank % 2 : bank - bank % 2 + 1;
        3: bank = (page == 0) ? bank - bank % 2 + 1 : bank - bank % 2;
        default: ;
      endcase
    end else begin
      bank = longint'(m_bank[int'(page)]);
    end
    off = bank * psz + rel % psz;
    sum = longint'(rom_base) + (off & longint'(rom_mask));
    return 27'(sum);
  endfunction

  task automatic model_write(input bit io, input logic c, input logic [15:0] a, input logic [7:0] d);
    if (m_var == 0 && !io && c && a >= 16'h4000 && a <= 16'h4003) m_bank[int'(a - 16'h4000)] = d;
    else if (m_var == 2 && !io && c && a >= 16'h4000 && a <= 16'h4001) m_bank[int'(a - 16'h4000)] = d;
    else if (m_var == 1 && io && a[7:0] == 8'h77) m_bank[0] = d;
  endtask

  task automatic model_reload();
    for (int i = 0; i < 4; i++) m_bank[i] = 8'(i);
  endtask

  task automatic bus_idle();
    cs = 1'b0; cpu_mreq = 1'b0; cpu_iorq = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
    cpu_addr = 16'h0000; cpu_data = 8'h00;
  endtask

  task automatic bus_write(input bit io, input logic c, input logic [15:0] a,
                           input logic [7:0] d, input int hold);
    @(negedge clk);
    cs = c; cpu_addr = a; cpu_data = d; cpu_mreq = !io; cpu_iorq = io; cpu_wr = 1'b1; cpu_rd = 1'b0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    bus_idle();
    model_write(io, c, a, d);
  endtask

  task automatic set_variant(input int v);
    @(negedge clk);
    variant = 2'(v);
    @(negedge clk);
    m_var = v;
    model_reload();
  endtask

  task automatic rd_check(input string tag, input logic c, input logic [15:0] a);
    logic [26:0] e;
    @(negedge clk);
    cs = c; cpu_addr = a; cpu_mreq = 1'b1; cpu_iorq = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b1;
    #1;
    e = exp_addr(c, a);
    chk(tag, 32'(out_addr), 32'(e));
    chk({tag, "_romcs"}, 32'(out_rom_cs), 32'(e != ONES));
  endtask

  task automatic rd_lit(input string tag, input logic [15:0] a, input logic [26:0] lit);
    @(negedge clk);
    cs = 1'b1; cpu_addr = a; cpu_mreq = 1'b1; cpu_iorq = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b1;
    #1;
    chk(tag, 32'(out_addr), 32'(lit));
  endtask

  initial begin
    reset = 1'b1; variant = 2'd0; rom_base = 27'h0; rom_mask = 27'h7FFFF;
    bus_idle();
    m_var = 0; model_reload();
    #12;
    chk("rst_addr", 32'(out_addr), 32'(ONES));
    chk("rst_romcs", 32'(out_rom_cs), 32'd0);
    chk("ramcs", 32'(out_ram_cs), 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);

    // Z80in1 reset banks and basic translation
    rd_lit("z80_a123", 16'hA123, 27'h06123);
    rd_check("z80_a123_m", 1'b1, 16'hA123);
    rd_check("z80_6000", 1'b1, 16'h6000);
    bus_write(1'b0, 1'b1, 16'h4002, 8'h05, 5);
    rd_lit("z80_8010", 16'h8010, 27'h0A010);
    rd_check("z80_0010", 1'b1, 16'h0010);
    rd_check("z80_cs0", 1'b0, 16'h8010);

    // Held write with data changing mid-strobe commits only the first value
    @(negedge clk);
    cs = 1'b1; cpu_addr = 16'h4003; cpu_data = 8'h07; cpu_mreq = 1'b1; cpu_wr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); cpu_data = 8'h09;
    repeat (3) @(posedge clk);
    @(negedge clk); bus_idle();
    m_bank[3] = 8'h07;
    rd_lit("z80_held", 16'hA000, 27'h0E000);

    // New bank visible the cycle after commit, not before
    @(negedge clk);
    cs = 1'b1; cpu_addr = 16'h4000; cpu_data = 8'h07; cpu_mreq = 1'b1; cpu_wr = 1'b1;
    #1 chk("lat_before", 32'(out_addr), 32'(exp_addr(1'b1, 16'h4000)));
    chk("wr_romcs", 32'(out_rom_cs), 32'd0);
    @(negedge clk);
    m_bank[0] = 8'h07;
    #1 chk("lat_after", 32'(out_addr), 32'(exp_addr(1'b1, 16'h4000)));
    @(negedge clk); bus_idle();

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1)
        bus_write(1'b0, $urandom_range(0, 3) != 0, 16'(16'h4000 + $urandom_range(0, 5)),
                  8'($urandom), 1 + $urandom_range(0, 2));
      rd_check("z80_rnd", $urandom_range(0, 7) != 0, 16'(16'h3000 + $urandom_range(0, 16'h9FFF)));
    end

    // Z126in1
    set_variant(2);
    rd_check("z126_reload", 1'b1, 16'h9000);
    bus_write(1'b0, 1'b1, 16'h4001, 8'h03, 2);
    rd_lit("z126_9000", 16'h9000, 27'h0D000);
    bus_write(1'b0, 1'b0, 16'h4000, 8'h55, 1);
    rd_lit("z126_cs0", 16'h4000, 27'h00000);
    for (int i = 0; i < 16; i++) begin
      bus_write(1'b0, 1'b1, 16'(16'h4000 + $urandom_range(0, 2)), 8'($urandom), 1);
      rd_check("z126_rnd", 1'b1, 16'($urandom));
    end

    // Z90in1
    set_variant(1);
    bus_write(1'b1, 1'b0, 16'h0077, 8'h85, 1);
    rd_lit("z90_m2_p1", 16'h4000, 27'h10000);
    rd_lit("z90_m2_p2", 16'h8000, 27'h14000);
    bus_write(1'b1, 1'b0, 16'h0077, 8'hC5, 1);
    rd_lit("z90_m3_p1", 16'h4000, 27'h14000);
    rd_lit("z90_m3_p2", 16'h8000, 27'h10000);
    for (int i = 0; i < 16; i++) begin
      bus_write(1'b1, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? 16'h0076 : {8'($urandom), 8'h77}, 8'($urandom), 1);
      rd_check("z90_rnd", 1'b1, 16'($urandom));
    end

    // Bank wrap through the mask, then base offset
    set_variant(2);
    rom_mask = 27'h1FFFF;
    bus_write(1'b0, 1'b1, 16'h4000, 8'h0A, 1);
    rd_lit("wrap", 16'h4000, 27'h08000);
    rom_base = 27'h100000;
    rd_lit("wrap_base", 16'h4000, 27'h108000);
    rd_check("wrap_base_m", 1'b1, 16'hBFFF);
    rom_base = 27'h0; rom_mask = 27'h7FFFF;

    // Variant change reloads registers
    set_variant(1);
    bus_write(1'b1, 1'b0, 16'h0077, 8'h85, 1);
    set_variant(0);
    rd_lit("sw_b0", 16'h4000, 27'h00000);
    rd_lit("sw_b3", 16'hA000, 27'h06000);

    // Write in the same cycle as a variant change is dropped, even if held
    @(negedge clk);
    variant = 2'd2;
    cs = 1'b1; cpu_addr = 16'h4000; cpu_data = 8'h66; cpu_mreq = 1'b1; cpu_wr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); bus_idle();
    m_var = 2; model_reload();
    rd_check("sw_drop", 1'b1, 16'h4000);

    // Async reset mid-write: immediate effect, no commit after release
    set_variant(0);
    bus_write(1'b0, 1'b1, 16'h4000, 8'h0B, 1);
    @(negedge clk);
    cs = 1'b1; cpu_addr = 16'h4001; cpu_data = 8'h44; cpu_mreq = 1'b1; cpu_wr = 1'b1;
    #2 reset = 1'b1;
    #1 model_reload();
    chk("async_rst", 32'(out_addr), 32'(exp_addr(1'b1, 16'h4001)));
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); bus_idle();
    rd_check("rst_nocommit", 1'b1, 16'h6000);

    // Variant 3 never maps
    set_variant(3);
    rd_check("none", 1'b1, 16'h4000);
    @(negedge clk); bus_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
